// File: rtl/urm_pkg.sv
// Shared definitions for the ultrasonic range module front end: sequencer
// state encoding, default clock rate and microsecond counter widths.
package urm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StWaitFall,
    StHoldoff
  } urm_state_e;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  // Microsecond-resolution counter widths.
  localparam int unsigned TimerW  = 15;
  localparam int unsigned PeriodW = 17;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/urm_if.sv
// Control/status bundle between the range-module sequencer and its user.
interface urm_if;
  logic enable;
  logic echo;
  logic trigger;
  logic busy;
  logic done;
  logic timeout;
  logic echo_sync;

  modport slave (
    input  enable,
    input  echo,
    output trigger,
    output busy,
    output done,
    output timeout,
    output echo_sync
  );

  modport master (
    output enable,
    output echo,
    input  trigger,
    input  busy,
    input  done,
    input  timeout,
    input  echo_sync
  );
endinterface

// File: rtl/urm_us_tick.sv
// Microsecond prescaler: one-clock tick every DIV clocks, restartable by a
// synchronous clear so the next tick is a full period away.
module urm_us_tick
  import urm_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/urm_trigger.sv
// Ultrasonic range module sequencer: fires the trigger pulse, supervises the
// echo rise/fall windows and paces measurements to a minimum period.
module urm_trigger
  import urm_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned PERIOD_US  = 60000
) (
  input logic  clk_i,
  input logic  rst_ni,
  urm_if.slave bus_io
);

  localparam int unsigned        Div     = CLK_HZ / 1_000_000;
  localparam logic [TimerW-1:0]  TrigLim = TimerW'(TRIG_US);
  localparam logic [TimerW-1:0]  ToLim   = TimerW'(TIMEOUT_US);
  localparam logic [PeriodW-1:0] PerLim  = PeriodW'(PERIOD_US);

  urm_state_e         state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d, timer_lim;
  logic [PeriodW-1:0] period_q, period_d;
  logic               echo_meta_q, echo_sync_q;
  logic               trigger_q, trigger_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               state_chg;
  logic               tick;

  assign state_chg = (state_d != state_q);

  urm_us_tick #(
    .DIV (Div)
  ) u_us_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_chg),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    trigger_d = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.enable && !echo_sync_q) state_d = StTrig;
      end
      StTrig: begin
        if (timer_q == TrigLim) state_d = StWaitRise;
        else                    trigger_d = 1'b1;
      end
      StWaitRise: begin
        if (echo_sync_q) begin
          state_d = StWaitFall;
        end else if (timer_q == ToLim) begin
          state_d   = StHoldoff;
          timeout_d = 1'b1;
        end
      end
      StWaitFall: begin
        // Echo edge takes priority over a timeout in the same clock.
        if (!echo_sync_q) begin
          state_d = StHoldoff;
          done_d  = 1'b1;
        end else if (timer_q == ToLim) begin
          state_d   = StHoldoff;
          timeout_d = 1'b1;
        end
      end
      StHoldoff: begin
        if (period_q == PerLim) begin
          state_d = (bus_io.enable && !echo_sync_q) ? StTrig : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign timer_lim = (state_q == StTrig) ? TrigLim : ToLim;

  always_comb begin
    timer_d = timer_q;
    if (state_chg) begin
      timer_d = '0;
    end else if (tick && (timer_q != timer_lim)) begin
      timer_d = timer_q + 1'b1;
    end

    period_d = period_q;
    if ((state_d == StTrig) && (state_q != StTrig)) begin
      period_d = '0;
    end else if (tick && (period_q != PerLim)) begin
      period_d = period_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      period_q    <= '0;
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      trigger_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      echo_meta_q <= bus_io.echo;
      echo_sync_q <= echo_meta_q;
      trigger_q   <= trigger_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus_io.trigger   = trigger_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = done_q;
  assign bus_io.timeout   = timeout_q;
  assign bus_io.echo_sync = echo_sync_q;

endmodule

// File: doc/urm_trigger.md
Name: urm_trigger

Overview:
- Front-end sequencer for the ultrasonic range module. It issues the 10 us trigger pulse, supervises the echo line, and enforces a fixed measurement period.
- Sits directly upstream of the echo-width/distance stage and shares the module's Echo pin with it.
- Reports per-cycle completion or timeout so downstream display logic can hold or blank the distance.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz. Must be an integer multiple of 1000000.
- TRIG_US, 10: trigger high time in microseconds, 1..1023.
- TIMEOUT_US, 30000: maximum wait, in microseconds, for the echo rise and, separately, for the echo fall.
- PERIOD_US, 60000: minimum time, in microseconds, from one trigger rise to the next.

Ports:
- Clock  input  1  system clock, 50 MHz
- Reset_n  input  1  asynchronous, active-low reset
- Enable  input  1  level; 1 = run periodic measurements
- Echo  input  1  raw echo pin, asynchronous to Clock
- Trigger  output  1  trigger pin to the range module, registered
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-clock pulse: echo fell within TIMEOUT_US
- Timeout  output  1  one-clock pulse: echo rise or echo fall missed its window
- EchoSync  output  1  two-flop synchronised Echo, for the downstream stage

Behaviour:
- Reset:
  - Trigger, Busy, Done, Timeout and EchoSync are 0.
  - State is IDLE and all counters are 0.
  - Assertion takes effect asynchronously. Trigger drops immediately, even mid-pulse.
- Microsecond tick:
  - A prescaler counts 0..CLK_HZ/1000000-1 and tick = 1 on the terminal count.
  - The prescaler clears on every state transition, so each state's first microsecond is a full microsecond.
- Echo input:
  - Synchronised with 2 flops. All FSM decisions use the synchronised value.
  - Latency from the pin to the FSM is 2 clocks.
- Period counter:
  - 17-bit microsecond counter, cleared on entry to TRIG and incremented on each tick.
  - Saturates at PERIOD_US.
- IDLE:
  - Go to TRIG when Enable=1 and EchoSync=0.
  - If EchoSync=1 (stale echo), stay in IDLE until it goes low.
- TRIG:
  - Trigger=1 starting the clock after entry, for exactly TRIG_US*CLK_HZ/1e6 clocks (500 clocks by default).
  - Then Trigger=0 and go to WAIT_RISE.
- WAIT_RISE:
  - Timer cleared on entry.
  - EchoSync=1 → go to WAIT_FALL.
  - Timer reaches TIMEOUT_US → pulse Timeout and go to HOLDOFF.
- WAIT_FALL:
  - Timer cleared on entry.
  - EchoSync=0 → pulse Done and go to HOLDOFF.
  - Timer reaches TIMEOUT_US → pulse Timeout and go to HOLDOFF.
- Simultaneous echo edge and timeout in the same clock: the echo wins. WAIT_FALL reports Done, not Timeout.
- HOLDOFF:
  - Leave when the period counter has reached PERIOD_US.
  - If Enable=1 and EchoSync=0, go directly to TRIG with no IDLE cycle. Otherwise go to IDLE.
  - If PERIOD_US is already reached on entry, exit on the next clock.
- Enable deasserted mid-cycle: the current cycle runs to completion, including HOLDOFF, then the FSM rests in IDLE. Trigger is never truncated by Enable.
- Done and Timeout:
  - Mutually exclusive, at most one pulse per cycle.
  - Registered, asserted the clock after the deciding condition.
- Counter widths:
  - Timer: 15 bits.
  - Period counter: 17 bits.
  - Prescaler: clog2(CLK_HZ/1e6) bits.
  - No wrap is possible, because all counters saturate or clear before overflow.

Decomposition:
- Shared package urm_pkg holds:
  - the state encoding: IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF;
  - the constant CLK_HZ_DEFAULT;
  - the microsecond width constants.
- One natural sub-module, urm_us_tick: the prescaler with a synchronous clear, producing a one-clock tick per microsecond. The echo stage can later reuse it in place of its own clock divider.

Test Plan:
- Use a small PERIOD_US=300 and TIMEOUT_US=100 for the simulation runs.
- Scenario 1: Reset_n low, then high with Enable=1 and Echo=0 → Trigger high for exactly 500 clocks, starting 1 clock after leaving IDLE.
- Scenario 2: Echo driven high 20 us after the trigger fall, for 58 us → Done pulses once, about 2–3 clocks after the Echo fall. The next Trigger rise comes 300 us after the previous rise.
- Scenario 3: Echo never rises → Timeout pulses once at 100 us after the trigger fall. There is no Done, and the period is still 300 us.
- Scenario 4: Echo rises and then stays high → Timeout 100 us after the rise. The FSM then holds in IDLE until Echo=0, then triggers.
- Scenario 5: Echo falls in the exact clock the WAIT_FALL timer expires → Done=1 and Timeout=0.
- Scenario 6: Enable dropped during TRIG, and Reset_n pulsed mid-TRIG on a second run:
  - First run: the full pulse and the cycle complete, then the FSM stays IDLE.
  - Second run: Trigger goes to 0 asynchronously and all outputs are 0.
